mem_resp: RTL

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_resp.sv
// Single-port word memory serving an instruction-fetch port and a load/store port,
// one request at a time with a fixed, parameterised response latency.
module mem_resp #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic [31:0] io_ifu_rdata,
  output logic        io_ifu_respValid,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic [31:0] io_lsu_rdata,
  output logic        io_lsu_respValid,
  output logic        err
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {SRC_IFU, SRC_LSU} src_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  src_e             src_q, src_d;
  logic             fault_q, fault_d;
  logic             wen_q, wen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      ifu_rdata_q, ifu_rdata_d;
  logic [31:0]      lsu_rdata_q, lsu_rdata_d;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      mem_rd_q;

  logic [31:0]      ifu_off, lsu_off;
  logic             ifu_range_ok, lsu_range_ok, lsu_size_fault;
  logic             resp_act, commit, rd_en;
  logic [31:0]      resp_word;

  // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both bounds.
  assign ifu_off      = io_ifu_addr - BASE_ADDR;
  assign lsu_off      = io_lsu_addr - BASE_ADDR;
  assign ifu_range_ok = {1'b0, ifu_off} < MEM_BYTES;
  assign lsu_range_ok = {1'b0, lsu_off} < MEM_BYTES;

  always_comb begin
    lsu_size_fault = 1'b0;
    case (io_lsu_size)
      2'd0:    lsu_size_fault = 1'b0;
      2'd1:    lsu_size_fault = io_lsu_addr[0];
      2'd2:    lsu_size_fault = |io_lsu_addr[1:0];
      default: lsu_size_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    fault_d = fault_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (io_lsu_reqValid) begin
          src_d   = SRC_LSU;
          fault_d = !lsu_range_ok || lsu_size_fault;
          wen_d   = io_lsu_wen;
          idx_d   = lsu_off[IDX_W+1:2];
          wdata_d = io_lsu_wdata;
          wmask_d = io_lsu_wmask;
        end else if (io_ifu_reqValid) begin
          src_d   = SRC_IFU;
          fault_d = !ifu_range_ok;
          wen_d   = 1'b0;
          idx_d   = ifu_off[IDX_W+1:2];
          wdata_d = '0;
          wmask_d = '0;
        end
        if (io_lsu_reqValid || io_ifu_reqValid) begin
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == 4'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      src_q       <= SRC_IFU;
      fault_q     <= 1'b0;
      wen_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      fault_q     <= fault_d;
      wen_q       <= wen_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // The word is read on the edge that enters RESP so it is ready during the RESP cycle.
  assign resp_act = (state_q == RESP);
  assign rd_en    = (state_d == RESP);
  assign commit   = resp_act && (src_q == SRC_LSU) && wen_q && !fault_q;

  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      mem_rd_q <= mem_q[idx_d];
    end
  end

  assign resp_word        = fault_q ? 32'd0 : mem_rd_q;
  assign io_ifu_respValid = resp_act && (src_q == SRC_IFU);
  assign io_lsu_respValid = resp_act && (src_q == SRC_LSU);
  assign err              = resp_act && fault_q;
  assign io_ifu_rdata     = io_ifu_respValid ? resp_word : ifu_rdata_q;
  assign io_lsu_rdata     = io_lsu_respValid ? resp_word : lsu_rdata_q;
  assign ifu_rdata_d      = io_ifu_rdata;
  assign lsu_rdata_d      = io_lsu_rdata;

endmodule
